// File: rtl/fir_s2p3_if.sv
// Sample-stream bundle between a single-rate source, the serial-to-parallel
// stage and the 3-parallel FIR input it feeds.
interface fir_s2p3_if #(
    parameter int NB = 14
);
    logic [NB-1:0] din;
    logic          vin;
    logic          sync;
    logic [NB-1:0] dout1;
    logic [NB-1:0] dout2;
    logic [NB-1:0] dout3;
    logic          vout;
    logic [1:0]    phase;
    logic          drop;

    modport master (
        output din, vin, sync,
        input  dout1, dout2, dout3, vout, phase, drop
    );

    modport slave (
        input  din, vin, sync,
        output dout1, dout2, dout3, vout, phase, drop
    );
endinterface

// File: rtl/fir_s2p3.sv
// Groups a serial sample stream into aligned triplets x[3k..3k+2] and
// strobes each complete triplet onto the 3-parallel FIR input.
module fir_s2p3 #(
    parameter int NB = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_s2p3_if.slave     bus
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t        p_reg;
    logic [NB-1:0] s0_reg;
    logic [NB-1:0] s1_reg;
    logic [NB-1:0] dout1_reg;
    logic [NB-1:0] dout2_reg;
    logic [NB-1:0] dout3_reg;
    logic          vout_reg;
    logic          drop_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg     <= PH0;
            s0_reg    <= '0;
            s1_reg    <= '0;
            dout1_reg <= '0;
            dout2_reg <= '0;
            dout3_reg <= '0;
            vout_reg  <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            vout_reg <= 1'b0;
            drop_reg <= 1'b0;
            if (bus.sync) begin
                // Realign: any held partial triplet is discarded and flagged.
                drop_reg <= (p_reg != PH0);
                if (bus.vin) begin
                    s0_reg <= bus.din;
                    p_reg  <= PH1;
                end else begin
                    p_reg  <= PH0;
                end
            end else if (bus.vin) begin
                case (p_reg)
                    PH0: begin
                        s0_reg <= bus.din;
                        p_reg  <= PH1;
                    end
                    PH1: begin
                        s1_reg <= bus.din;
                        p_reg  <= PH2;
                    end
                    PH2: begin
                        dout1_reg <= s0_reg;
                        dout2_reg <= s1_reg;
                        dout3_reg <= bus.din;
                        vout_reg  <= 1'b1;
                        p_reg     <= PH0;
                    end
                    default: p_reg <= PH0;
                endcase
            end else if (p_reg == PH3) begin
                // Unreachable state recovers on the next edge even while idle.
                p_reg <= PH0;
            end
        end
    end

    assign bus.dout1 = dout1_reg;
    assign bus.dout2 = dout2_reg;
    assign bus.dout3 = dout3_reg;
    assign bus.vout  = vout_reg;
    assign bus.phase = p_reg;
    assign bus.drop  = drop_reg;

endmodule

// File: tb/tb_fir_s2p3.sv
// Directed bench for fir_s2p3: triplet grouping, gaps, sync realignment,
// asynchronous reset mid-triplet and bit-exact extreme values.
module tb_fir_s2p3;

    localparam int NB = 14;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    fir_s2p3_if #(.NB(NB)) bus ();

    fir_s2p3 #(.NB(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_trip(input string tag, input logic [NB-1:0] a,
                            input logic [NB-1:0] b, input logic [NB-1:0] c);
        chk(tag, {22'd0, bus.dout1, bus.dout2, bus.dout3}, {22'd0, a, b, c});
    endtask

    // Inputs change on the falling edge; outputs are observed on the next one.
    task automatic push(input logic v, input logic s, input logic [NB-1:0] d);
        bus.vin  = v;
        bus.sync = s;
        bus.din  = d;
        @(negedge clk);
        $display("t=%0t vin=%b sync=%b din=%h -> vout=%b phase=%0d drop=%b dout=%h/%h/%h",
                 $time, v, s, d, bus.vout, bus.phase, bus.drop,
                 bus.dout1, bus.dout2, bus.dout3);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.vin  = 1'b0;
        bus.sync = 1'b0;
        bus.din  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_trip",  {40'd0, bus.dout1, bus.dout2, bus.dout3}, 64'd0);
        chk("rst_vout",  {63'd0, bus.vout}, 64'd0);
        chk("rst_phase", {62'd0, bus.phase}, 64'd0);
        chk("rst_drop",  {63'd0, bus.drop}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: continuous 1..6
        for (int i = 1; i <= 6; i++) begin
            push(1'b1, 1'b0, NB'(i));
            chk($sformatf("t1_phase%0d", i), {62'd0, bus.phase}, 64'(i % 3));
            chk($sformatf("t1_vout%0d", i), {63'd0, bus.vout}, 64'(i % 3 == 0));
            if (i == 3) chk_trip("t1_trip_a", 14'd1, 14'd2, 14'd3);
        end
        chk_trip("t1_trip_b", 14'd4, 14'd5, 14'd6);
        push(1'b0, 1'b0, '0);
        chk("t1_vout_idle", {63'd0, bus.vout}, 64'd0);

        // 2: gapped input, then hold
        push(1'b1, 1'b0, 14'h0010);
        push(1'b0, 1'b0, 14'h1234);
        push(1'b0, 1'b0, 14'h1234);
        chk("t2_phase_gap", {62'd0, bus.phase}, 64'd1);
        chk("t2_vout_gap", {63'd0, bus.vout}, 64'd0);
        push(1'b1, 1'b0, 14'h3FFF);
        push(1'b0, 1'b0, 14'h0AAA);
        chk("t2_phase2", {62'd0, bus.phase}, 64'd2);
        push(1'b1, 1'b0, 14'h2000);
        chk("t2_vout", {63'd0, bus.vout}, 64'd1);
        chk_trip("t2_trip", 14'h0010, 14'h3FFF, 14'h2000);
        for (int i = 0; i < 5; i++) begin
            push(1'b0, 1'b0, 14'h1555);
            chk($sformatf("t2_hold_vout%0d", i), {63'd0, bus.vout}, 64'd0);
            chk_trip($sformatf("t2_hold_trip%0d", i), 14'h0010, 14'h3FFF, 14'h2000);
        end

        // 3: sync mid-triplet discards 7,8
        push(1'b1, 1'b0, 14'd7);
        push(1'b1, 1'b0, 14'd8);
        chk("t3_phase2", {62'd0, bus.phase}, 64'd2);
        push(1'b1, 1'b1, 14'd9);
        chk("t3_drop", {63'd0, bus.drop}, 64'd1);
        chk("t3_vout", {63'd0, bus.vout}, 64'd0);
        chk("t3_phase1", {62'd0, bus.phase}, 64'd1);
        push(1'b1, 1'b0, 14'd10);
        chk("t3_drop_clr", {63'd0, bus.drop}, 64'd0);
        push(1'b1, 1'b0, 14'd11);
        chk("t3_vout_trip", {63'd0, bus.vout}, 64'd1);
        chk_trip("t3_trip", 14'd9, 14'd10, 14'd11);

        // 4: sync at phase 0 without data; then sync at phase 1 without data
        push(1'b0, 1'b1, 14'd0);
        chk("t4_drop0", {63'd0, bus.drop}, 64'd0);
        chk("t4_phase0", {62'd0, bus.phase}, 64'd0);
        chk("t4_vout0", {63'd0, bus.vout}, 64'd0);
        push(1'b1, 1'b0, 14'd5);
        push(1'b0, 1'b1, 14'd0);
        chk("t4_drop1", {63'd0, bus.drop}, 64'd1);
        chk("t4_phase_sync", {62'd0, bus.phase}, 64'd0);

        // 5: asynchronous reset between 2nd and 3rd sample
        push(1'b1, 1'b0, 14'h0AAA);
        push(1'b1, 1'b0, 14'h0BBB);
        bus.vin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_trip", {40'd0, bus.dout1, bus.dout2, bus.dout3}, 64'd0);
        chk("t5_async_phase", {62'd0, bus.phase}, 64'd0);
        chk("t5_async_vout", {63'd0, bus.vout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 1'b0, 14'h1111);
        push(1'b1, 1'b0, 14'h2222);
        chk("t5_phase2", {62'd0, bus.phase}, 64'd2);
        push(1'b1, 1'b0, 14'h3333);
        chk("t5_vout", {63'd0, bus.vout}, 64'd1);
        chk_trip("t5_trip", 14'h1111, 14'h2222, 14'h3333);

        // 6: extreme two's-complement values pass bit-exact
        push(1'b1, 1'b0, 14'h2000);
        push(1'b1, 1'b0, 14'h1FFF);
        push(1'b1, 1'b0, 14'h3FFF);
        chk("t6_vout", {63'd0, bus.vout}, 64'd1);
        chk_trip("t6_trip", 14'h2000, 14'h1FFF, 14'h3FFF);
        push(1'b0, 1'b0, '0);
        chk("t6_vout_single", {63'd0, bus.vout}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_s2p3.md
Name: fir_s2p3

Overview:
- Serial-to-parallel input stage placed directly upstream of the 3-way unfolded pipelined FIR (myfir).
- Accepts one 14-bit sample per valid cycle from a single-rate source.
- Groups consecutive samples into aligned triplets x[3k], x[3k+1], x[3k+2].
- Presents each triplet on din1/din2/din3 with a one-cycle vin strobe, matching the FIR's 3-parallel input.

Parameters:
NB, 14, sample width in bits (two's complement, passed through unmodified)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
din  in  NB  serial input sample
vin  in  1  din valid this cycle
sync  in  1  realign: the current/next valid sample becomes x[3k] of a new triplet
dout1  out  NB  triplet sample x[3k] (oldest), drives FIR din1
dout2  out  NB  triplet sample x[3k+1], drives FIR din2
dout3  out  NB  triplet sample x[3k+2] (newest), drives FIR din3
vout  out  1  one-cycle strobe: dout1..3 hold a new complete triplet
phase  out  2  number of samples currently held in the partial triplet (0..2)
drop  out  1  one-cycle pulse: a partial triplet was discarded by sync

Behaviour:
- Reset (rst_n=0, asynchronous):
  - dout1..3=0, vout=0, phase=0, drop=0.
  - Internal holding registers s0, s1 cleared.
  - Applies immediately, mid-triplet included; any partial data is lost silently (no drop pulse).
- Phase counter p ∈ {0,1,2}, exposed as phase. Value 3 is unreachable; if it is ever reached, the next edge forces p=0.
- Normal operation, at each rising clk edge with vin=1 and sync=0:
  - p=0: s0<=din, p<=1.
  - p=1: s1<=din, p<=2.
  - p=2: dout1<=s0, dout2<=s1, dout3<=din, vout<=1, p<=0.
- vin=0 and sync=0: p, s0, s1 unchanged; vout<=0.
- vout:
  - Registered; high exactly one cycle, in the cycle after the edge that captured the third sample.
  - Latency from third din valid to vout: 1 clk.
  - Back-to-back triplets give vout high every 3rd cycle when vin is continuous; never on consecutive cycles.
- dout1..3 update only when vout is set. Between strobes they hold the last triplet, so the FIR samples them only on vout.
- sync handling (sync has priority over normal phase progression):
  - sync=1, vin=1: din taken as new x[3k] (s0<=din, p<=1); vout<=0.
  - sync=1, vin=0: p<=0; s0, s1 unchanged (don't care); vout<=0.
  - In both cases drop<=1 iff p≠0 before the edge, else drop<=0. drop is a registered one-cycle pulse.
  - sync while p=2 with vin=1 discards the two held samples; no triplet is emitted.
- Arithmetic: none. Samples are passed bit-exact, no sign extension or rounding.
- Throughput: one input sample per clk max; output one triplet per 3 valid inputs. The FIR therefore runs at 1/3 strobe rate.
- No backpressure: the downstream FIR must accept vout every cycle it is asserted.

Test Plan:
1. Reset then continuous vin, din=1,2,3,4,5,6 on consecutive cycles -> vout high in cycles 4 and 7 (1 clk after 3rd/6th sample); triplets (1,2,3) then (4,5,6); phase sequence 1,2,0,1,2,0.
2. Gapped vin: samples 0x0010, idle 2 cycles, 0x3FFF, idle 1, 0x2000 -> single vout one cycle after 0x2000; dout=(0x0010,0x3FFF,0x2000); outputs hold values through 5 subsequent idle cycles.
3. Sync mid-triplet: din 7,8 (phase=2), then sync=1 with vin=1, din=9, followed by 10,11 -> drop pulse one cycle after 9; next triplet (9,10,11); 7,8 never appear on outputs.
4. Sync at phase 0 with vin=0 -> drop stays 0, phase stays 0, no vout.
5. Async reset asserted between 2nd and 3rd sample of a triplet, mid-clock-period -> dout1..3, vout, phase go to 0 immediately without a clock edge. After release, samples 0x1111,0x2222,0x3333 give a correct triplet with no leftover data.
6. Width/sign: triplet (0x2000, 0x1FFF, 0x3FFF) with NB=14 -> outputs bit-identical (most negative, most positive, -1), no sign extension artefacts.
